// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered reads, write bypass,
// and a self-sweeping clear that zeroes storage after reset or on request.
module regfile_2r1w #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              clr,
    output logic [WIDTH-1:0]  ra_data,
    output logic [WIDTH-1:0]  rb_data,
    output logic              busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic w_ok;
    logic ra_ok;
    logic rb_ok;
    logic wr_hit;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] ra_idx;
    logic [IDX_W-1:0] rb_idx;
    logic [IDX_W-1:0] c_idx;

    assign w_ok   = {1'b0, waddr}   < DEPTH_X;
    assign ra_ok  = {1'b0, ra_addr} < DEPTH_X;
    assign rb_ok  = {1'b0, rb_addr} < DEPTH_X;
    assign wr_hit = we && (state == IDLE) && w_ok;

    // Indices are only used once the address is known to be in range.
    assign w_idx  = waddr[IDX_W-1:0];
    assign ra_idx = ra_addr[IDX_W-1:0];
    assign rb_idx = rb_addr[IDX_W-1:0];
    assign c_idx  = cnt[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep is the only source of zeros.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[c_idx] <= '0;
        end else if (wr_hit) begin
            mem[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_data <= '0;
            rb_data <= '0;
        end else if (state == CLEAR) begin
            ra_data <= '0;
            rb_data <= '0;
        end else begin
            if (!ra_ok) begin
                ra_data <= '0;
            end else if (wr_hit && (waddr == ra_addr)) begin
                ra_data <= wdata;
            end else begin
                ra_data <= mem[ra_idx];
            end
            if (!rb_ok) begin
                rb_data <= '0;
            end else if (wr_hit && (waddr == rb_addr)) begin
                rb_data <= wdata;
            end else begin
                rb_data <= mem[rb_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: expected outputs are queued per clock edge
// and checked by an independent monitor on the falling edge.
module tb_regfile_2r1w;

    logic       clk;
    logic       rst_n, we, clr;
    logic [4:0] waddr, ra_addr, rb_addr;
    logic [7:0] wdata, ra_data, rb_data;
    logic       busy;

    logic       b_rst_n, b_we, b_clr;
    logic [4:0] b_waddr, b_ra_addr, b_rb_addr;
    logic [7:0] b_wdata, b_ra_data, b_rb_data;
    logic       b_busy;

    regfile_2r1w #(.WIDTH(8), .DEPTH(32), .ADDR_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .clr(clr),
        .ra_data(ra_data), .rb_data(rb_data), .busy(busy)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(20), .ADDR_W(5)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .we(b_we), .waddr(b_waddr),
        .wdata(b_wdata), .ra_addr(b_ra_addr), .rb_addr(b_rb_addr),
        .clr(b_clr), .ra_data(b_ra_data), .rb_data(b_rb_data),
        .busy(b_busy)
    );

    typedef struct {
        int         edge_n;
        int         dut;
        string      name;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       bsy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    int   sel = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic set_in(input logic w, input logic [4:0] wa,
                          input logic [7:0] wd, input logic [4:0] ra,
                          input logic [4:0] rb, input logic c);
        if (sel == 0) begin
            we = w; waddr = wa; wdata = wd;
            ra_addr = ra; rb_addr = rb; clr = c;
        end else begin
            b_we = w; b_waddr = wa; b_wdata = wd;
            b_ra_addr = ra; b_rb_addr = rb; b_clr = c;
        end
    endtask

    task automatic step(input string name, input logic [7:0] era,
                        input logic [7:0] erb, input logic eb);
        exp_t e;
        e.edge_n = edge_cnt + 1;
        e.dut    = sel;
        e.name   = name;
        e.ra     = era;
        e.rb     = erb;
        e.bsy    = eb;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic sweep_chk(input string name, input int n);
        for (int i = 1; i <= n; i++) begin
            step(name, 8'h00, 8'h00, (i < n));
        end
    endtask

    // Monitor: pops every expectation whose edge has just occurred.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].edge_n <= edge_cnt) begin
                exp_t       e;
                logic [7:0] gra, grb;
                logic       gb;
                e = q.pop_front();
                gra = (e.dut == 0) ? ra_data : b_ra_data;
                grb = (e.dut == 0) ? rb_data : b_rb_data;
                gb  = (e.dut == 0) ? busy : b_busy;
                n_cmp++;
                if (e.edge_n != edge_cnt) begin
                    n_bad++;
                    $display("FAIL %s: stale check edge %0d at edge %0d",
                             e.name, e.edge_n, edge_cnt);
                end else if (gra !== e.ra || grb !== e.rb || gb !== e.bsy) begin
                    n_bad++;
                    $display("FAIL %s @%0d: got ra=%h rb=%h busy=%b want ra=%h rb=%h busy=%b",
                             e.name, edge_cnt, gra, grb, gb, e.ra, e.rb, e.bsy);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        sel = 1; set_in(0, 0, 0, 0, 0, 0);
        sel = 0; set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Power-on: held in reset, then one full sweep
        repeat (3) step("rst_hold", 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        sweep_chk("por_sweep", 32);
        set_in(0, 0, 0, 5'd3, 5'd31, 0);
        step("post_por_rd", 8'h00, 8'h00, 1'b0);

        // Write then dual read of the same entry
        set_in(1, 5'd2, 8'hA5, 5'd0, 5'd1, 0);
        step("wr_a5", 8'h00, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd2, 5'd2, 0);
        step("rd_a5_both", 8'hA5, 8'hA5, 1'b0);

        // Bypass on each port
        set_in(1, 5'd7, 8'h3C, 5'd7, 5'd2, 0);
        step("byp_a", 8'h3C, 8'hA5, 1'b0);
        set_in(0, 0, 0, 5'd7, 5'd7, 0);
        step("rd_3c", 8'h3C, 8'h3C, 1'b0);
        set_in(1, 5'd9, 8'h5A, 5'd2, 5'd9, 0);
        step("byp_b", 8'hA5, 8'h5A, 1'b0);

        // Clear with writes attempted and clr re-pulsed during busy
        set_in(1, 5'd4, 8'h77, 5'd0, 5'd0, 0);
        step("wr_77", 8'h00, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd4, 5'd9, 1);
        step("clr_edge", 8'h77, 8'h5A, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            set_in(1, 5'd4, 8'hFF, 5'd4, 5'd7, (i == 5));
            step("clr_sweep", 8'h00, 8'h00, (i < 32));
        end
        set_in(0, 0, 0, 5'd4, 5'd7, 0);
        step("after_clr4", 8'h00, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd2, 5'd9, 0);
        step("after_clr2", 8'h00, 8'h00, 1'b0);

        // Same-edge write and clr: write lands, then is swept
        set_in(1, 5'd6, 8'hEE, 5'd6, 5'd0, 1);
        step("wr_clr", 8'hEE, 8'h00, 1'b1);
        set_in(0, 0, 0, 0, 0, 0);
        sweep_chk("wr_clr_sweep", 32);
        set_in(0, 0, 0, 5'd6, 5'd6, 0);
        step("after_wr_clr", 8'h00, 8'h00, 1'b0);

        // Reset in the middle of a sweep restarts it
        set_in(1, 5'd1, 8'h42, 5'd0, 5'd0, 0);
        step("wr_42", 8'h00, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd1, 5'd1, 1);
        step("clr2_edge", 8'h42, 8'h42, 1'b1);
        set_in(0, 0, 0, 5'd1, 5'd1, 0);
        repeat (10) step("pre_rst", 8'h00, 8'h00, 1'b1);
        rst_n = 1'b0;
        repeat (2) step("mid_rst", 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        sweep_chk("re_sweep", 32);
        step("after_re", 8'h00, 8'h00, 1'b0);

        // DEPTH=20 instance: range checks and a shorter sweep
        sel = 1;
        b_rst_n = 1'b1;
        sweep_chk("b_por", 20);
        set_in(1, 5'd25, 8'h11, 5'd25, 5'd5, 0);
        step("b_wr_oor", 8'h00, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd25, 5'd5, 0);
        step("b_rd_oor", 8'h00, 8'h00, 1'b0);
        set_in(1, 5'd19, 8'h33, 5'd19, 5'd0, 0);
        step("b_byp_last", 8'h33, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd19, 5'd25, 0);
        step("b_rd_last", 8'h33, 8'h00, 1'b0);
        set_in(0, 0, 0, 5'd19, 5'd19, 1);
        step("b_clr", 8'h33, 8'h33, 1'b1);
        set_in(0, 0, 0, 5'd19, 5'd19, 0);
        sweep_chk("b_sweep", 20);
        step("b_after", 8'h00, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked (edge %0d)", e.name, e.edge_n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries, 2..2^ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 5, address width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port we  input  1  write enable, sampled at rising clk.
REQ-007 SHALL have port waddr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  WIDTH  write data.
REQ-009 SHALL have port ra_addr  input  ADDR_W  read port A address.
REQ-010 SHALL have port rb_addr  input  ADDR_W  read port B address.
REQ-011 SHALL have port clr  input  1  single-cycle request to zero every entry.
REQ-012 SHALL have port ra_data  output  WIDTH  registered read port A data.
REQ-013 SHALL have port rb_data  output  WIDTH  registered read port B data.
REQ-014 SHALL have port busy  output  1  high while the clear sweep runs; writes ignored.

Function
REQ-015 SHALL hold DEPTH x WIDTH storage; one write port, two independent read ports, all on the rising clk edge (no negedge logic).
REQ-016 SHALL have 1-cycle read latency: ra_data/rb_data after edge N = entry at ra_addr/rb_addr sampled at edge N.
REQ-017 SHALL bypass same-edge writes: if we=1, busy=0, and waddr equals a read address at edge N, that port outputs wdata after edge N.
REQ-018 SHALL let both read ports address the same entry concurrently with identical results.
REQ-019 SHALL drop writes with waddr >= DEPTH (no storage change, no aliasing).
REQ-020 SHALL return 0 on a read port whose address >= DEPTH.
REQ-021 SHALL implement FSM states IDLE and CLEAR with an ADDR_W-bit sweep counter cnt.
REQ-022 SHALL, in IDLE, on clr=1 at an edge: go to CLEAR, cnt=0, busy=1 after that edge.
REQ-023 SHALL, in CLEAR, at each edge write 0 to entry cnt and increment cnt; at the edge writing entry DEPTH-1 go to IDLE, busy=0 after that edge.
REQ-024 SHALL keep busy high for exactly DEPTH rising edges per sweep.
REQ-025 SHALL ignore we while busy=1 (no write, no bypass).
REQ-026 SHALL ignore clr while in CLEAR (no restart, no extension).
REQ-027 SHALL drive ra_data and rb_data to 0 at every edge while busy=1.
REQ-028 SHALL, on same-edge clr=1 and we=1 in IDLE, perform the write, then start the sweep, which zeroes that entry.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force ra_data=0, rb_data=0, busy=1, state=CLEAR, cnt=0.
REQ-030 SHALL, after rst_n rises, run a full sweep: busy falls after the DEPTH-th rising edge; storage is all-zero from then on.
REQ-031 SHALL, if rst_n asserts mid-sweep or mid-operation, abandon the current activity and restart the sweep from cnt=0 on release.
REQ-032 SHALL not require storage to be reset by flops; zero contents come only from the sweep.

Verification
REQ-033 Reset release, defaults, count edges -> busy=1 for exactly 32 edges, then 0; read of any address returns 0x00.
REQ-034 After sweep, write 0xA5 to addr 2, then ra_addr=2, rb_addr=2 next cycle -> both ports read 0xA5 one edge later.
REQ-035 we=1, waddr=7, wdata=0x3C, ra_addr=7 at the same edge, old contents 0x00 -> ra_data=0x3C after that edge (bypass).
REQ-036 Pulse clr, assert we=1 waddr=4 wdata=0xFF during busy -> write ignored; after 32 edges busy=0, addr 4 reads 0x00.
REQ-037 DEPTH=20 ADDR_W=5: write 0x11 to addr 25, read addr 25 and addr 5 -> both 0x00 (drop, no aliasing); busy period 20 edges.
REQ-038 Assert rst_n low at sweep edge 10 for 2 cycles, release -> busy stays high a further 32 edges; ra_data=rb_data=0 throughout.
